// File: rtl/io_input_cond.sv
// Input conditioning for board switches and push-buttons: 2-flop synchroniser,
// stability-counter debounce, and a registered one-cycle press pulse per button.
module io_input_cond #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int BTN_ACTIVE_LOW  = 1,
   parameter int N_SW            = 32,
   parameter int N_BTN           = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [N_SW-1:0]  i_sw_raw,
   input  logic [N_BTN-1:0] i_btn_raw,
   output logic [N_SW-1:0]  o_io_sw,
   output logic [N_BTN-1:0] o_io_btn,
   output logic [N_BTN-1:0] o_btn_press
);

   localparam int               CW       = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]    CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [N_BTN-1:0] BTN_IDLE = (BTN_ACTIVE_LOW != 0) ? {N_BTN{1'b1}} : {N_BTN{1'b0}};

   logic [N_SW-1:0]  r_sw_s1, r_sw_s2, r_sw_prev, r_io_sw;
   logic [CW-1:0]    r_sw_cnt;

   logic [N_BTN-1:0] r_btn_s1, r_btn_s2, r_io_btn, r_btn_press;
   logic [CW-1:0]    r_btn_cnt [N_BTN];

   logic [N_BTN-1:0] w_btn_p, w_btn_nxt, w_press_nxt;
   logic [CW-1:0]    w_btn_cnt_nxt [N_BTN];

   // Normalised to active-high "pressed" after the synchroniser.
   assign w_btn_p = r_btn_s2 ^ BTN_IDLE;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      w_btn_nxt     = r_io_btn;
      w_press_nxt   = '0;
      w_btn_cnt_nxt = r_btn_cnt;
      for (int i = 0; i < N_BTN; i++) begin
         if (w_btn_p[i] == r_io_btn[i]) begin
            w_btn_cnt_nxt[i] = '0;
         end else if (r_btn_cnt[i] == CNT_MAX) begin
            w_btn_nxt[i]     = w_btn_p[i];
            w_press_nxt[i]   = w_btn_p[i];
            w_btn_cnt_nxt[i] = '0;
         end else begin
            w_btn_cnt_nxt[i] = r_btn_cnt[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_btn_s1    <= BTN_IDLE;
         r_btn_s2    <= BTN_IDLE;
         r_io_btn    <= '0;
         r_btn_press <= '0;
         // NOTE: the counter array is reset too, so a reset mid-count always restarts debounce.
         for (int i = 0; i < N_BTN; i++) r_btn_cnt[i] <= '0;
      end else begin
         r_btn_s1    <= i_btn_raw;
         r_btn_s2    <= r_btn_s1;
         r_io_btn    <= w_btn_nxt;
         r_btn_press <= w_press_nxt;
         r_btn_cnt   <= w_btn_cnt_nxt;
      end
   end

   // Switches share one counter so the whole vector updates atomically.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sw_s1   <= '0;
         r_sw_s2   <= '0;
         r_sw_prev <= '0;
         r_io_sw   <= '0;
         r_sw_cnt  <= '0;
      end else begin
         r_sw_s1   <= i_sw_raw;
         r_sw_s2   <= r_sw_s1;
         r_sw_prev <= r_sw_s2;
         if (r_sw_s2 == r_io_sw || r_sw_s2 != r_sw_prev) begin
            r_sw_cnt <= '0;
         end else if (r_sw_cnt == CNT_MAX) begin
            r_io_sw  <= r_sw_s2;
            r_sw_cnt <= '0;
         end else begin
            r_sw_cnt <= r_sw_cnt + 1'b1;
         end
      end
   end

   assign o_io_sw     = r_io_sw;
   assign o_io_btn    = r_io_btn;
   assign o_btn_press = r_btn_press;

endmodule
